fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ requesters in the w_clk domain.
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Drives the FIFO's w_en/w_data and gates every transfer on the FIFO full flag, so no beat is ever lost or duplicated.

---
 rtl/fifo_write_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Grants bursts of up to MAX_BURST beats; every transfer is gated by the FIFO full flag.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_last_q, rr_last_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]   winner;
    logic            found;

    // First set request searching from the requester after the last owner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(rr_last_q) + k) % NUM_REQ]) begin
                winner = OW'((int'(rr_last_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        gnt        = '0;
        w_en       = 1'b0;
        w_data     = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d    = IDLE;
                    rr_last_d  = owner_q;
                    beat_cnt_d = '0;
                end else if (!full) begin
                    gnt[owner_q] = 1'b1;
                    w_en         = 1'b1;
                    w_data       = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
                    if (req_last[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        rr_last_d  = owner_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A cycle with reset asserted must never write, even mid-burst.
        if (!resetn) begin
            gnt    = '0;
            w_en   = 1'b0;
            w_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_last_q  <= OW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle comparison against a rule-level model
// plus literal expectations on the logged write stream.
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_last = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             full = 1'b0;
    logic [N-1:0]     gnt;
    logic             w_en;
    logic [W-1:0]     w_data;
    logic [1:0]       owner;
    logic             busy;

    int nrun = 0;
    int nfail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit mgrant = 1'b0;
    int mown = 0;
    int mcnt = 0;
    int mrr = N - 1;

    logic [N-1:0] gq[$];
    logic [W-1:0] dq[$];
    int           cq[$];

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_data(req_data),
        .req_last(req_last), .full(full), .gnt(gnt), .w_en(w_en),
        .w_data(w_data), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nrun++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(int last, logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    function automatic bit exp_xfer();
        return resetn && mgrant && req[mown] && !full;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Rule-level model: who owns the port, how many beats taken, who went last.
    always @(posedge clk) begin
        if (!resetn) begin
            mgrant <= 1'b0; mown <= 0; mcnt <= 0; mrr <= N - 1;
        end else if (!mgrant) begin
            if (req != '0) begin
                mown <= rr_pick(mrr, req); mcnt <= 0; mgrant <= 1'b1;
            end
        end else if (!req[mown]) begin
            mgrant <= 1'b0; mrr <= mown; mcnt <= 0;
        end else if (!full) begin
            if (req_last[mown] || mcnt + 1 == MB) begin
                mgrant <= 1'b0; mrr <= mown; mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt",    gnt,    exp_xfer() ? (4'b0001 << mown) : 4'b0000);
            chk("w_en",   w_en,   exp_xfer());
            chk("w_data", w_data, exp_xfer() ? req_data[mown*W +: W] : 32'h0);
            chk("owner",  owner,  mown[1:0]);
            chk("busy",   busy,   mgrant);
            if (w_en === 1'b1) begin
                gq.push_back(gnt); dq.push_back(w_data); cq.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setd(int i, logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic clr();
        gq.delete(); dq.delete(); cq.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0; req = '0; req_last = '0; full = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int rc;
        // Reset then idle
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_wen", w_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_wdata", w_data, 32'h0);
        resetn = 1'b1;
        tick();

        // Single requester, 3-beat burst ended by req_last
        clr();
        rc = cyc;
        setd(2, 32'hA0); req = 4'b0100;
        tick();
        for (int b = 0; b < 3; b++) begin
            setd(2, 32'hA0 + b); req_last[2] = (b == 2);
            tick();
        end
        req = '0; req_last = '0;
        @(negedge clk);
        chk("single_busy", busy, 1'b0);
        chk("single_owner", owner, 2'd2);
        chk("single_cnt", dq.size(), 3);
        for (int k = 0; k < 3 && k < dq.size(); k++) begin
            chk("single_data", dq[k], 32'hA0 + k);
            chk("single_gnt", gq[k], 4'b0100);
        end
        if (cq.size() == 3) begin
            chk("single_latency", cq[0] - rc, 1);
            chk("single_back2back", cq[2] - cq[0], 2);
        end

        // Round robin with burst cap, all requesting
        do_reset();
        clr();
        for (int i = 0; i < N; i++) setd(i, 32'hC000 + i);
        req = 4'b1111;
        repeat (25) tick();
        req = '0;
        tick();
        chk("rr_cnt", dq.size(), 20);
        for (int k = 0; k < 20 && k < gq.size(); k++) begin
            chk("rr_gnt", gq[k], 4'b0001 << ((k / 4) % 4));
            if (k % 4 == 0 && k > 0) chk("rr_gap", cq[k] - cq[k-1], 2);
        end

        // Full stall after beat 2 of owner 1
        do_reset();
        clr();
        setd(1, 32'hB0); req = 4'b0010;
        tick();
        tick(); setd(1, 32'hB1);
        tick(); setd(1, 32'hB2); full = 1'b1;
        repeat (5) tick();
        full = 1'b0;
        tick(); setd(1, 32'hB3);
        tick(); req = '0;
        @(negedge clk);
        chk("stall_busy", busy, 1'b0);
        chk("stall_owner", owner, 2'd1);
        chk("stall_cnt", dq.size(), 4);
        for (int k = 0; k < 4 && k < dq.size(); k++) chk("stall_data", dq[k], 32'hB0 + k);
        if (cq.size() == 4) begin
            chk("stall_gap", cq[2] - cq[1], 6);
            chk("stall_resume", cq[3] - cq[2], 1);
        end

        // Abandon by owner 3, pending requester 0 wins next
        do_reset();
        setd(3, 32'hD0); req = 4'b1000;
        tick();
        tick(); req = 4'b0101; setd(0, 32'hE0);
        @(negedge clk);
        chk("abandon_wen", w_en, 1'b0);
        chk("abandon_busy", busy, 1'b1);
        tick();
        @(negedge clk);
        chk("abandon_idle", busy, 1'b0);
        chk("abandon_owner", owner, 2'd3);
        tick();
        @(negedge clk);
        chk("abandon_next_gnt", gnt, 4'b0001);
        chk("abandon_next_data", w_data, 32'hE0);
        req = '0;
        tick(); tick();

        // Reset asserted during owner 2's second beat
        do_reset();
        setd(2, 32'hF0); req = 4'b0100;
        tick();
        tick(); setd(2, 32'hF1); resetn = 1'b0;
        @(negedge clk);
        chk("midrst_wen", w_en, 1'b0);
        chk("midrst_gnt", gnt, 4'b0000);
        tick(); resetn = 1'b1; req = 4'b0101; setd(0, 32'hF8);
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_owner", owner, 2'd0);
        tick();
        @(negedge clk);
        chk("midrst_next_gnt", gnt, 4'b0001);
        chk("midrst_next_data", w_data, 32'hF8);
        req = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
